// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback path: data/register widths and the
// entry format carried from the producers to the register file.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One pending writeback result: destination register plus its value.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Writeback FIFO with two ordered push ports and an always-popping head.
// Port 0 is the older of two same-cycle pushes. The head leaves at every
// clock edge while the queue is non-empty, so the consumer never stalls.
// A flat entry/valid view is exported for the bypass search.
import riscv_pkg::*;

module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push0_valid_i,
    input  wb_entry_t                       push0_entry_i,
    input  logic                            push1_valid_i,
    input  wb_entry_t                       push1_entry_i,
    output wb_entry_t                       head_entry_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic [$clog2(DEPTH)-1:0]        head_ptr_o,
    output wb_entry_t                       entries_o [DEPTH],
    output logic [DEPTH-1:0]                valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         entries_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     headPtr_q, headPtr_d;
    logic [PW-1:0]     tailPtr_q, tailPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              popEn;
    logic [PW-1:0]     push1Slot;
    logic [CW-1:0]     pushCount;

    // Next-state arithmetic: the head pops whenever something is queued, and
    // the second push lands just behind the first one if both are present.
    always_comb begin
        popEn     = (count_q != '0);
        pushCount = CW'(push0_valid_i) + CW'(push1_valid_i);
        push1Slot = tailPtr_q + PW'(push0_valid_i);
        headPtr_d = headPtr_q + PW'(popEn);
        tailPtr_d = tailPtr_q + PW'(push0_valid_i) + PW'(push1_valid_i);
        count_d   = count_q + pushCount - CW'(popEn);
    end

    // Control state: pointers, occupancy and per-slot valid bits. On a full
    // queue the tail equals the head, so the pop clear is ordered before the
    // push set to let the incoming entry reclaim the slot that is leaving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            valid_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            if (popEn) begin
                valid_q[headPtr_q] <= 1'b0;
            end
            if (push0_valid_i) begin
                valid_q[tailPtr_q] <= 1'b1;
            end
            if (push1_valid_i) begin
                valid_q[push1Slot] <= 1'b1;
            end
        end
    end

    // Entry payload storage; contents only matter where the valid bit is set,
    // so the data array carries no reset.
    always_ff @(posedge clk) begin
        if (push0_valid_i) begin
            entries_q[tailPtr_q] <= push0_entry_i;
        end
        if (push1_valid_i) begin
            entries_q[push1Slot] <= push1_entry_i;
        end
    end

    assign head_entry_o = entries_q[headPtr_q];
    assign count_o      = count_q;
    assign head_ptr_o   = headPtr_q;
    assign entries_o    = entries_q;
    assign valid_o      = valid_q;

    // The top-level ready logic must never let occupancy exceed the storage.
    assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write initiator. Collects ALU and LSU writeback results,
// drops writes to x0, queues the rest in LSU-before-ALU order and drains one
// entry per cycle onto the register file port. Decode can peek at pending
// results through two bypass lookup ports (youngest match wins).
import riscv_pkg::*;

module regwrite_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid_i,
    input  logic [4:0]        alu_rd_i,
    input  logic [31:0]       alu_data_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [4:0]        lsu_rd_i,
    input  logic [31:0]       lsu_data_i,
    output logic              lsu_ready_o,
    output logic [31:0]       reg_wr_data_o,
    output logic [4:0]        reg_wr_addr_o,
    output logic              ctl_reg_we_o,
    input  logic [4:0]        byp_r1_i,
    input  logic [4:0]        byp_r2_i,
    output logic              byp_hit1_o,
    output logic              byp_hit2_o,
    output logic [31:0]       byp_data1_o,
    output logic [31:0]       byp_data2_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              lsuReq, aluReq;
    logic              lsuX0, aluX0;
    logic              lsuPush, aluPush;
    logic [CW-1:0]     count;
    logic [CW-1:0]     freeSlots;
    logic [PW-1:0]     headPtr;
    logic [PW-1:0]     slot;
    wb_entry_t         headEntry;
    wb_entry_t         lsuEntry, aluEntry;
    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  validBits;

    // Qualify requests, count usable slots (the head always leaves this
    // cycle) and grant the LSU first when only one slot is available.
    always_comb begin
        lsuX0     = lsu_valid_i && (lsu_rd_i == '0);
        aluX0     = alu_valid_i && (alu_rd_i == '0);
        lsuReq    = lsu_valid_i && (lsu_rd_i != '0);
        aluReq    = alu_valid_i && (alu_rd_i != '0);
        freeSlots = CW'(DEPTH) - count + CW'(count != '0);
        lsu_ready_o = (freeSlots >= CW'(1)) || lsuX0;
        alu_ready_o = (freeSlots >= CW'(2))
                   || ((freeSlots >= CW'(1)) && !lsuReq)
                   || aluX0;
        lsuPush  = lsuReq && lsu_ready_o;
        aluPush  = aluReq && alu_ready_o;
        lsuEntry = '{rd: lsu_rd_i, data: lsu_data_i};
        aluEntry = '{rd: alu_rd_i, data: alu_data_i};
    end

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .push0_valid_i (lsuPush),
        .push0_entry_i (lsuEntry),
        .push1_valid_i (aluPush),
        .push1_entry_i (aluEntry),
        .head_entry_o  (headEntry),
        .count_o       (count),
        .head_ptr_o    (headPtr),
        .entries_o     (entries),
        .valid_o       (validBits)
    );

    // Write port is driven purely from registered queue state; idle reads 0.
    always_comb begin
        ctl_reg_we_o  = (count != '0);
        reg_wr_addr_o = ctl_reg_we_o ? headEntry.rd   : '0;
        reg_wr_data_o = ctl_reg_we_o ? headEntry.data : '0;
    end

    // Bypass search walks oldest to youngest from the head so that the last
    // match seen is the youngest; x0 lookups never hit.
    always_comb begin
        byp_hit1_o  = 1'b0;
        byp_hit2_o  = 1'b0;
        byp_data1_o = '0;
        byp_data2_o = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = headPtr + PW'(i);
            if (validBits[slot] && (byp_r1_i != '0) && (entries[slot].rd == byp_r1_i)) begin
                byp_hit1_o  = 1'b1;
                byp_data1_o = entries[slot].data;
            end
            if (validBits[slot] && (byp_r2_i != '0) && (entries[slot].rd == byp_r2_i)) begin
                byp_hit2_o  = 1'b1;
                byp_data2_o = entries[slot].data;
            end
        end
    end

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Write-side initiator for the register file. Accepts writeback results from two producers, the ALU and the load/store unit (LSU), over valid/ready handshakes. Queues them in program order in a small FIFO and drains one entry per cycle onto the register file write port (`reg_wr_data`, `reg_wr_addr`, `ctl_reg_we`). Exposes a two-port bypass lookup so decode can read results still pending in the queue.

## Interface

Parameters:
- `DEPTH`, default 4: queue entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid_i`  in  1  ALU result valid.
- `alu_rd_i`  in  5  ALU destination register.
- `alu_data_i`  in  32  ALU result.
- `alu_ready_o`  out  1  ALU result accepted this cycle when valid.
- `lsu_valid_i`  in  1  LSU result valid.
- `lsu_rd_i`  in  5  LSU destination register.
- `lsu_data_i`  in  32  LSU result.
- `lsu_ready_o`  out  1  LSU result accepted this cycle when valid.
- `reg_wr_data_o`  out  32  write data to the register file.
- `reg_wr_addr_o`  out  5  write register to the register file.
- `ctl_reg_we_o`  out  1  write enable to the register file.
- `byp_r1_i`, `byp_r2_i`  in  5  bypass lookup addresses.
- `byp_hit1_o`, `byp_hit2_o`  out  1  a pending entry targets that address.
- `byp_data1_o`, `byp_data2_o`  out  32  data of the youngest matching pending entry. Zero when there is no hit.

## Operation

- **Request qualification.**
  - `lsu_req = lsu_valid_i && lsu_rd_i != 0`; `alu_req` is defined likewise.
  - A valid with rd = 0 is a request to x0. It is handshaken (ready high) and discarded; it is never enqueued.
- **Free slots.** `free = DEPTH - count + (count != 0)`. The head always drains this cycle, so a full queue still accepts one entry.
- **Ready.**
  - `lsu_ready_o = (free >= 1)`.
  - `alu_ready_o = (free >= 2) || (free >= 1 && !lsu_req)`.
  - Both readies are high for x0 requests regardless of `free`.
  - Ready may depend combinationally on the valids and rd fields. Producers must not make valid depend on ready.
- **Ordering.** If both producers are accepted in the same cycle, the LSU entry is enqueued first (older), then the ALU entry. When only one slot is free, the LSU wins.
- **Drain.**
  - Whenever `count != 0`: `ctl_reg_we_o = 1`, and `reg_wr_addr_o`/`reg_wr_data_o` present the head entry. The head pops at that clock edge.
  - When the queue is empty, all three outputs are 0.
  - Outputs are combinational from the registered head entry and count (no combinational path from the producer inputs).
- **Bypass.**
  - For each lookup port, search every occupied entry (including the head); the youngest match wins.
  - Address 0 never hits.
  - Entries accepted in the current cycle are not visible to bypass until the next cycle.
- **Arithmetic.**
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `count` is log2(DEPTH)+1 bits and updates as `count + pushes - pop`, with pushes ∈ {0,1,2} and pop ∈ {0,1}.
  - Overflow is impossible by construction; an assertion checks `count <= DEPTH`.

## Timing

- **Reset.** Asynchronous. Clears count, pointers and entry valid bits. Every output reads 0 except `alu_ready_o`/`lsu_ready_o`, which read 1 (queue empty).
- **Write latency.** A result accepted at edge N drives `ctl_reg_we_o` during cycle N..N+1 and is written to the register file at edge N+1, provided the queue was empty. Each older entry ahead of it adds one cycle.
- **Throughput.** One write per cycle sustained. Two simultaneous producers fill the queue at a net +1 per cycle until `alu_ready_o` drops.
- **Reset mid-operation.** All pending entries are lost and `ctl_reg_we_o` deasserts immediately. No partial write is issued after reset asserts.

## Structure

- Shared package `riscv_pkg` holds `XLEN = 32`, `REG_AW = 5`, and the writeback entry struct `{rd[4:0], data[31:0]}`.
- Sub-module `wb_queue`: a DEPTH-entry FIFO with two push ports (ordered), one always-pop head, and a flat entry/valid view for the bypass search.
- The top level contains the ready logic, x0 filtering and bypass priority muxes.

## Test plan

- After reset, `alu_valid_i=1`, `alu_rd_i=5`, `alu_data_i=0xDEADBEEF` for one cycle → the next cycle shows `ctl_reg_we_o=1`, `reg_wr_addr_o=5`, data 0xDEADBEEF. On that cycle, `byp_r1_i=5` gives hit, 0xDEADBEEF.
- Both valid in the same cycle (LSU rd=3 data=0x11, ALU rd=3 data=0x22) → the write port shows 0x11 then 0x22 on consecutive cycles. Bypass for 3 returns 0x22 while both are pending.
- `lsu_valid_i=1` with `lsu_rd_i=0` → `lsu_ready_o=1`, no write issued, count unchanged, no bypass hit for address 0.
- DEPTH=4, both producers valid every cycle → `alu_ready_o` drops once free <2. 100 random results all written in LSU-before-ALU per-cycle order, none lost or duplicated.
- Assert `rst_n` low with 3 entries queued → `ctl_reg_we_o` goes 0 immediately, count=0, readies 1. After release, the first new result writes at latency 1.
